// File: rtl/riscv_noc_pkg.sv
// -----------------------------------------------------------------------------
// riscv_noc_pkg
// Shared NoC definitions used by the channel multiplexer, the packet buffer
// and the router.
//   PLEN_DEFAULT : default flit payload width in bits
//   noc_flit_t   : flit as carried between blocks, {last, flit}
// -----------------------------------------------------------------------------
package riscv_noc_pkg;

   localparam int unsigned PLEN_DEFAULT = 64;

   typedef struct packed {
      logic                    last;
      logic [PLEN_DEFAULT-1:0] flit;
   } noc_flit_t;

endpackage

// File: rtl/riscv_noc_buffer_ram.sv
// -----------------------------------------------------------------------------
// riscv_noc_buffer_ram
// DEPTH x WIDTH flit storage: one synchronous write port and one asynchronous
// read port. Contents are not reset; validity is tracked by the owner.
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module riscv_noc_buffer_ram
   import riscv_noc_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = PLEN_DEFAULT + 1
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/riscv_noc_packet_buffer.sv
// -----------------------------------------------------------------------------
// riscv_noc_packet_buffer
// Flit FIFO behind the NoC channel multiplexer. Absorbs router back-pressure,
// stores {last, flit} per entry and reports flit/packet occupancy. With
// FULLPACKET = 1 the head is only offered once a complete packet is stored,
// or in cut-through when the buffer fills without holding any last flit.
//   clk          : clock, rising edge
//   rst          : synchronous reset, active-high
//   in_flit      : flit from the channel multiplexer
//   in_last      : flit ends its packet
//   in_valid     : upstream flit valid
//   in_ready     : buffer accepts a flit this cycle (registered)
//   out_flit     : head flit
//   out_last     : head flit ends its packet
//   out_valid    : head flit valid
//   out_ready    : downstream accepts the head flit
//   flit_count   : flits stored
//   packet_count : last flits stored (complete packets)
// -----------------------------------------------------------------------------
module riscv_noc_packet_buffer
   import riscv_noc_pkg::*;
#(
   parameter int unsigned PLEN       = PLEN_DEFAULT,
   parameter int unsigned DEPTH      = 16,
   parameter bit          FULLPACKET = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [PLEN-1:0]            in_flit,
   input  logic                       in_last,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [PLEN-1:0]            out_flit,
   output logic                       out_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] flit_count,
   output logic [$clog2(DEPTH+1)-1:0] packet_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] flit_cnt_q;
   logic [CNT_W-1:0] pkt_cnt_q;
   logic [CNT_W-1:0] flit_cnt_d;
   logic [CNT_W-1:0] pkt_cnt_d;
   logic             in_ready_q;
   logic             cut_q;
   logic             cut_through;
   logic             valid_int;
   logic             push;
   logic             pop;
   logic             pkt_inc;
   logic             pkt_dec;
   logic [PLEN:0]    rd_word;

   riscv_noc_buffer_ram #(
      .DEPTH (DEPTH),
      .WIDTH (PLEN + 1)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata ({in_last, in_flit}),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   assign push    = in_valid & in_ready_q;
   assign pop     = valid_int & out_ready;
   assign pkt_inc = push & in_last;
   assign pkt_dec = pop & rd_word[PLEN];

   // Cut-through asserts combinationally as soon as the buffer is full with no
   // last flit inside; the registered copy keeps it alive while the long
   // packet drains, until its last flit leaves.
   assign cut_through = cut_q | ((flit_cnt_q == CNT_FULL) && (pkt_cnt_q == '0));

   always_comb begin
      valid_int = (flit_cnt_q != '0);
      if (FULLPACKET) begin
         valid_int = (flit_cnt_q != '0) && ((pkt_cnt_q != '0) || cut_through);
      end
   end

   always_comb begin
      flit_cnt_d = flit_cnt_q;
      case ({push, pop})
         2'b10:   flit_cnt_d = flit_cnt_q + CNT_W'(1);
         2'b01:   flit_cnt_d = flit_cnt_q - CNT_W'(1);
         default: flit_cnt_d = flit_cnt_q;
      endcase
   end

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      case ({pkt_inc, pkt_dec})
         2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
         2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
         default: pkt_cnt_d = pkt_cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         flit_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         in_ready_q <= 1'b0;
         cut_q      <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         flit_cnt_q <= flit_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         // Ready is computed from next-state occupancy so it carries no
         // combinational path from out_ready.
         in_ready_q <= (flit_cnt_d != CNT_FULL);
         if (pkt_dec) begin
            cut_q <= 1'b0;
         end else begin
            cut_q <= cut_through;
         end
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = valid_int;
   assign out_flit     = rd_word[PLEN-1:0];
   assign out_last     = rd_word[PLEN];
   assign flit_count   = flit_cnt_q;
   assign packet_count = pkt_cnt_q;

endmodule

// File: tb/tb_riscv_noc_packet_buffer.sv
// -----------------------------------------------------------------------------
// tb_riscv_noc_packet_buffer
// Directed bench for riscv_noc_packet_buffer. Instance a: PLEN 64, DEPTH 16,
// plain FIFO. Instance b: PLEN 16, DEPTH 4, packet mode.
// -----------------------------------------------------------------------------
module tb_riscv_noc_packet_buffer;
   import riscv_noc_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   done    = 1'b0;

   always #5 clk = ~clk;

   // instance a
   logic [63:0] a_in_flit = '0;
   logic        a_in_last = 1'b0;
   logic        a_in_valid = 1'b0;
   logic        a_in_ready;
   logic [63:0] a_out_flit;
   logic        a_out_last;
   logic        a_out_valid;
   logic        a_out_ready = 1'b0;
   logic [4:0]  a_flit_count;
   logic [4:0]  a_packet_count;

   // instance b
   logic [15:0] b_in_flit = '0;
   logic        b_in_last = 1'b0;
   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [15:0] b_out_flit;
   logic        b_out_last;
   logic        b_out_valid;
   logic        b_out_ready = 1'b0;
   logic [2:0]  b_flit_count;
   logic [2:0]  b_packet_count;

   riscv_noc_packet_buffer #(
      .PLEN       (PLEN_DEFAULT),
      .DEPTH      (16),
      .FULLPACKET (1'b0)
   ) dut_a (
      .clk          (clk),
      .rst          (rst),
      .in_flit      (a_in_flit),
      .in_last      (a_in_last),
      .in_valid     (a_in_valid),
      .in_ready     (a_in_ready),
      .out_flit     (a_out_flit),
      .out_last     (a_out_last),
      .out_valid    (a_out_valid),
      .out_ready    (a_out_ready),
      .flit_count   (a_flit_count),
      .packet_count (a_packet_count)
   );

   riscv_noc_packet_buffer #(
      .PLEN       (16),
      .DEPTH      (4),
      .FULLPACKET (1'b1)
   ) dut_b (
      .clk          (clk),
      .rst          (rst),
      .in_flit      (b_in_flit),
      .in_last      (b_in_last),
      .in_valid     (b_in_valid),
      .in_ready     (b_in_ready),
      .out_flit     (b_out_flit),
      .out_last     (b_out_last),
      .out_valid    (b_out_valid),
      .out_ready    (b_out_ready),
      .flit_count   (b_flit_count),
      .packet_count (b_packet_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // occupancy bounds: never above DEPTH, packets never exceed flits
   always @(negedge clk) begin
      if (!rst && !done) begin
         chk("a_cnt_bound", 64'(a_flit_count <= 5'd16), 64'd1);
         chk("a_pkt_bound", 64'(a_packet_count <= a_flit_count), 64'd1);
         chk("b_cnt_bound", 64'(b_flit_count <= 3'd4), 64'd1);
         chk("b_pkt_bound", 64'(b_packet_count <= b_flit_count), 64'd1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tx;
      int rx;

      // ---------------- reset ----------------
      tick();
      tick();
      chk("rst_a_count", 64'(a_flit_count), 64'd0);
      chk("rst_a_pkt", 64'(a_packet_count), 64'd0);
      chk("rst_a_valid", 64'(a_out_valid), 64'd0);
      chk("rst_a_ready", 64'(a_in_ready), 64'd0);
      chk("rst_b_valid", 64'(b_out_valid), 64'd0);
      chk("rst_b_ready", 64'(b_in_ready), 64'd0);
      rst = 1'b0;
      tick();
      chk("rst_a_ready_up", 64'(a_in_ready), 64'd1);
      chk("rst_b_ready_up", 64'(b_in_ready), 64'd1);

      // ---------------- A, B, C into plain FIFO ----------------
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_last   = 1'b0;
      a_in_flit   = 64'hAAAA_0000_0000_0001;
      tick();
      chk("abc_latency_valid", 64'(a_out_valid), 64'd1);
      chk("abc_latency_flit", a_out_flit, 64'hAAAA_0000_0000_0001);
      a_in_flit = 64'hBBBB_0000_0000_0002;
      tick();
      a_in_flit = 64'hCCCC_0000_0000_0003;
      a_in_last = 1'b1;
      tick();
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
      chk("abc_count", 64'(a_flit_count), 64'd3);
      chk("abc_pkt", 64'(a_packet_count), 64'd1);
      chk("abc_valid", 64'(a_out_valid), 64'd1);
      chk("abc_head", a_out_flit, 64'hAAAA_0000_0000_0001);
      chk("abc_head_last", 64'(a_out_last), 64'd0);
      a_out_ready = 1'b1;
      tick();
      chk("abc_pop1_flit", a_out_flit, 64'hBBBB_0000_0000_0002);
      chk("abc_pop1_count", 64'(a_flit_count), 64'd2);
      tick();
      chk("abc_pop2_flit", a_out_flit, 64'hCCCC_0000_0000_0003);
      chk("abc_pop2_last", 64'(a_out_last), 64'd1);
      tick();
      a_out_ready = 1'b0;
      chk("abc_empty_valid", 64'(a_out_valid), 64'd0);
      chk("abc_empty_count", 64'(a_flit_count), 64'd0);
      chk("abc_empty_pkt", 64'(a_packet_count), 64'd0);

      // ---------------- streaming 3*DEPTH flits ----------------
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      for (int i = 0; i < 48; i++) begin
         a_in_flit = 64'hC0DE_0000_0000_0000 + 64'(i);
         a_in_last = ((i % 4) == 3);
         tick();
         chk("stream_valid", 64'(a_out_valid), 64'd1);
         chk("stream_data", a_out_flit, 64'hC0DE_0000_0000_0000 + 64'(i));
         chk("stream_count", 64'(a_flit_count), 64'd1);
         chk("stream_pkt", 64'(a_packet_count), 64'((i % 4) == 3));
         chk("stream_ready", 64'(a_in_ready), 64'd1);
      end
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
      tick();
      a_out_ready = 1'b0;
      chk("stream_end_count", 64'(a_flit_count), 64'd0);
      chk("stream_end_valid", 64'(a_out_valid), 64'd0);

      // ---------------- packet mode: 1-flit packet ----------------
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      b_in_last   = 1'b1;
      b_in_flit   = 16'h5151;
      tick();
      b_in_valid = 1'b0;
      chk("single_pkt", 64'(b_packet_count), 64'd1);
      chk("single_valid", 64'(b_out_valid), 64'd1);
      chk("single_flit", 64'(b_out_flit), 64'h5151);
      chk("single_last", 64'(b_out_last), 64'd1);
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
      chk("single_popped", 64'(b_out_valid), 64'd0);

      // ---------------- packet mode: 3-flit packet ----------------
      b_in_valid = 1'b1;
      b_in_last  = 1'b0;
      b_in_flit  = 16'h0A01;
      tick();
      chk("fp_hold1", 64'(b_out_valid), 64'd0);
      chk("fp_hold1_count", 64'(b_flit_count), 64'd1);
      b_in_flit = 16'h0A02;
      tick();
      chk("fp_hold2", 64'(b_out_valid), 64'd0);
      chk("fp_hold2_pkt", 64'(b_packet_count), 64'd0);
      b_in_flit = 16'h0A03;
      b_in_last = 1'b1;
      tick();
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
      chk("fp_release", 64'(b_out_valid), 64'd1);
      chk("fp_pkt", 64'(b_packet_count), 64'd1);
      chk("fp_count", 64'(b_flit_count), 64'd3);
      chk("fp_head", 64'(b_out_flit), 64'h0A01);
      b_out_ready = 1'b1;
      tick();
      chk("fp_d2", 64'(b_out_flit), 64'h0A02);
      chk("fp_d2_valid", 64'(b_out_valid), 64'd1);
      tick();
      chk("fp_d3", 64'(b_out_flit), 64'h0A03);
      chk("fp_d3_last", 64'(b_out_last), 64'd1);
      tick();
      b_out_ready = 1'b0;
      chk("fp_drained", 64'(b_out_valid), 64'd0);
      chk("fp_drained_pkt", 64'(b_packet_count), 64'd0);

      // ---------------- DEPTH=4 full, 5th held ----------------
      b_in_valid = 1'b1;
      b_in_last  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         b_in_flit = 16'hF000 + 16'(k);
         tick();
      end
      chk("full_ready", 64'(b_in_ready), 64'd0);
      chk("full_count", 64'(b_flit_count), 64'd4);
      chk("full_pkt", 64'(b_packet_count), 64'd4);
      chk("full_head", 64'(b_out_flit), 64'hF000);
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
      chk("pop1_ready", 64'(b_in_ready), 64'd1);
      chk("pop1_count", 64'(b_flit_count), 64'd3);
      chk("pop1_head", 64'(b_out_flit), 64'hF001);
      tick();
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
      chk("refill_count", 64'(b_flit_count), 64'd4);
      chk("refill_ready", 64'(b_in_ready), 64'd0);
      b_out_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         chk("full_drain_valid", 64'(b_out_valid), 64'd1);
         chk("full_drain_data", 64'(b_out_flit), 64'hF000 + 64'(k));
         tick();
      end
      b_out_ready = 1'b0;
      chk("full_drained", 64'(b_flit_count), 64'd0);

      // ---------------- 6-flit packet through DEPTH=4 (cut-through) ----------------
      tx = 0;
      rx = 0;
      b_out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
         b_in_valid = (tx < 6);
         b_in_flit  = 16'hC000 + 16'(tx);
         b_in_last  = (tx == 5);
         if (b_out_valid) begin
            if (rx == 0) begin
               chk("cut_at_full", 64'(b_flit_count), 64'd4);
            end
            chk("cut_data", 64'(b_out_flit), 64'hC000 + 64'(rx));
            chk("cut_last", 64'(b_out_last), 64'(rx == 5));
            rx++;
         end
         if (b_in_valid && b_in_ready) begin
            tx++;
         end
         tick();
      end
      b_in_valid  = 1'b0;
      b_in_last   = 1'b0;
      b_out_ready = 1'b0;
      chk("cut_delivered", 64'(rx), 64'd6);
      chk("cut_empty", 64'(b_flit_count), 64'd0);

      // cut-through must be gone: a fresh partial packet is held back
      b_in_valid = 1'b1;
      b_in_flit  = 16'hD001;
      tick();
      b_in_flit = 16'hD002;
      tick();
      b_in_valid = 1'b0;
      chk("cut_cleared", 64'(b_out_valid), 64'd0);
      chk("partial_count", 64'(b_flit_count), 64'd2);

      // ---------------- reset mid-packet ----------------
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_count", 64'(b_flit_count), 64'd0);
      chk("midrst_pkt", 64'(b_packet_count), 64'd0);
      chk("midrst_valid", 64'(b_out_valid), 64'd0);
      chk("midrst_ready", 64'(b_in_ready), 64'd0);
      tick();
      chk("midrst_ready_up", 64'(b_in_ready), 64'd1);
      chk("midrst_a_ready_up", 64'(a_in_ready), 64'd1);

      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
